// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter/sequencer for two requesters sharing one single-port RAM.
// Latency: grant on the first edge with a request; ack 3 edges later with a ready-on-2nd-edge RAM.
// Backpressure: RAM command is held until mem_ready; optional abort when MEM_ARB_TIMEOUT_EN is defined.
module memory_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  // port 0: instruction fetch
  input  logic       m0_req,
  input  logic       m0_read,
  input  logic       m0_write,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic [7:0] m0_rdata,
  output logic       m0_ack,
  // port 1: load/store
  input  logic       m1_req,
  input  logic       m1_read,
  input  logic       m1_write,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m1_rdata,
  output logic       m1_ack,
  // status
  output logic       err,
  output logic       busy,
  // RAM side
  output logic       mem_en,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_input_data,
  input  logic [7:0] mem_output_data,
  input  logic       mem_ready
);

  // The abort counter is 4 bits wide, so TIMEOUT must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("memory_arbiter: TIMEOUT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t     state, state_d;
  logic       gnt, gnt_d;          // port granted most recently (also the port being served)
  logic       grant, sel;          // grant a new access this edge, and to which port
  logic       en_d, rd_d, wr_d;
  logic [7:0] addr_d, wdat_d;
  logic [7:0] rdata0_d, rdata1_d;
  logic       ack0_d, ack1_d, err_d, busy_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
  logic [3:0] tmo_cnt;

  // Counts ACCESS cycles; zero whenever outside ACCESS so every access starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != ACCESS) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 4'd1;
    end
  end
`endif

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    en_d     = mem_en;
    rd_d     = mem_read;
    wr_d     = mem_write;
    addr_d   = mem_address;
    wdat_d   = mem_input_data;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    grant    = 1'b0;
    sel      = gnt;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant = 1'b1;
          // with both requesting, the port not served last wins
          sel   = (m0_req && m1_req) ? ~gnt : m1_req;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (mem_read) begin
            if (gnt) rdata1_d = mem_output_data;
            else     rdata0_d = mem_output_data;
          end
          ack0_d  = ~gnt;
          ack1_d  = gnt;
          en_d    = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RELEASE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          ack0_d  = ~gnt;
          ack1_d  = gnt;
          err_d   = 1'b1;
          en_d    = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RELEASE;
        end
`endif
      end
      RELEASE: begin
        // en is low this cycle so the RAM re-arms; only the other port may be granted
        if (gnt ? m0_req : m1_req) begin
          grant = 1'b1;
          sel   = ~gnt;
        end else begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      gnt_d  = sel;
      rd_d   = sel ? m1_read  : m0_read;
      wr_d   = sel ? m1_write : m0_write;
      addr_d = sel ? m1_addr  : m0_addr;
      wdat_d = sel ? m1_wdata : m0_wdata;
      if (rd_d ^ wr_d) begin
        en_d    = 1'b1;
        state_d = ACCESS;
      end else begin
        // read==write is not a command: complete it at once with err, RAM untouched
        en_d    = 1'b0;
        ack0_d  = ~sel;
        ack1_d  = sel;
        err_d   = 1'b1;
        state_d = RELEASE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset favours port 0 by marking port 1 as last served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      gnt            <= 1'b1;
      mem_en         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_input_data <= '0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      gnt            <= gnt_d;
      mem_en         <= en_d;
      mem_read       <= rd_d;
      mem_write      <= wr_d;
      mem_address    <= addr_d;
      mem_input_data <= wdat_d;
      m0_rdata       <= rdata0_d;
      m1_rdata       <= rdata1_d;
      m0_ack         <= ack0_d;
      m1_ack         <= ack1_d;
      err            <= err_d;
      busy           <= busy_d;
    end
  end

endmodule
